// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MNIST MLP result path: digit/result types
// and the active-low 7-segment decoder.
package mlp_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned SEG_W       = 7;
    localparam int unsigned NUM_CLASSES = 10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        logic   match;
        digit_t label;
        digit_t pred;
    } result_t;

    // Active-low {g..a}; anything outside 0-9 is shown blank.
    function automatic logic [SEG_W-1:0] seg7_decode(input digit_t d);
        logic [SEG_W-1:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Show-ahead result FIFO with registered head/valid; accepts a push while full
// when a pop happens in the same cycle.
module result_fifo
    import mlp_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clr_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  result_t wdata_i,
    output logic    valid_o,
    output result_t rdata_o,
    output logic    full_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    result_t       mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic          valid_q, valid_d;
    result_t       head_q, head_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_ok  = pop_i && valid_q;
        push_ok = push_i && (!full_c || pop_ok);
        wr_d    = wr_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        head_d  = head_q;
        if (clr_i) begin
            wr_d    = '0;
            rd_d    = '0;
            valid_d = 1'b0;
            head_d  = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PW'(1);
            if (pop_ok)  rd_d = rd_q + PW'(1);
            valid_d = (wr_d != rd_d);
            // Bypass the write data when the new head is the slot being written.
            if (!valid_d)
                head_d = '0;
            else if (push_ok && (rd_d[AW-1:0] == wr_q[AW-1:0]))
                head_d = wdata_i;
            else
                head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            if (!clr_i && push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = head_q;

endmodule

// File: rtl/inference_collector.sv
// Collects MLP inference results: match check, result FIFO, saturating
// accuracy counters, sticky overflow and 7-segment display of the last result.
module inference_collector
    import mlp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               output_en,
    input  logic [3:0]         inference_index,
    input  logic [3:0]         label_in,
    input  logic               clear,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [8:0]         rd_data,
    output logic [CNT_W-1:0]   total_count,
    output logic [CNT_W-1:0]   correct_count,
    output logic               overflow,
    output logic [SEG_W-1:0]   hex_pred,
    output logic [SEG_W-1:0]   hex_label
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    result_t            res_c;
    result_t            head;
    logic               strobe_c, pop_c, drop_c, full_c;
    logic [CNT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   correct_q, correct_d;
    logic               ovf_q, ovf_d;
    logic [SEG_W-1:0]   hp_q, hp_d;
    logic [SEG_W-1:0]   hl_q, hl_d;

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear),
        .push_i  (strobe_c),
        .pop_i   (rd_ready),
        .wdata_i (res_c),
        .valid_o (rd_valid),
        .rdata_o (head),
        .full_c  (full_c)
    );

    // Clear wins over a coincident strobe, so the strobe is masked here.
    always_comb begin
        strobe_c    = output_en && !clear;
        pop_c       = rd_valid && rd_ready;
        res_c.pred  = inference_index;
        res_c.label = label_in;
        res_c.match = (inference_index == label_in) &&
                      (inference_index < digit_t'(NUM_CLASSES));
        drop_c      = strobe_c && full_c && !pop_c;

        total_d   = total_q;
        correct_d = correct_q;
        ovf_d     = ovf_q;
        hp_d      = hp_q;
        hl_d      = hl_q;
        if (clear) begin
            total_d   = '0;
            correct_d = '0;
            ovf_d     = 1'b0;
            hp_d      = SEG_BLANK;
            hl_d      = SEG_BLANK;
        end else if (strobe_c) begin
            if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
            if (res_c.match && (correct_q != CNT_MAX)) correct_d = correct_q + CNT_W'(1);
            if (drop_c) ovf_d = 1'b1;
            hp_d = seg7_decode(inference_index);
            hl_d = seg7_decode(label_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q   <= '0;
            correct_q <= '0;
            ovf_q     <= 1'b0;
            hp_q      <= SEG_BLANK;
            hl_q      <= SEG_BLANK;
        end else begin
            total_q   <= total_d;
            correct_q <= correct_d;
            ovf_q     <= ovf_d;
            hp_q      <= hp_d;
            hl_q      <= hl_d;
        end
    end

    assign rd_data       = head;
    assign total_count   = total_q;
    assign correct_count = correct_q;
    assign overflow      = ovf_q;
    assign hex_pred      = hp_q;
    assign hex_label     = hl_q;

endmodule
